// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer.
// Launched by a one-cycle Start pulse; results land on Hi/Lo when Done pulses.
module mult_div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [PW-1:0]      prod;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   dvsr;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic               a_sign;
   logic               b_sign;

   logic [WIDTH:0]     upper;
   logic [WIDTH:0]     mcand_x;
   logic [WIDTH:0]     booth_sum;
   logic [PW-1:0]      prod_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic               rem_ge;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? WIDTH'(-x) : x;
   endfunction

   // One Booth step and one restoring-division step, evaluated every cycle.
   always_comb begin
      upper     = prod[PW-1:WIDTH+1];
      mcand_x   = {mcand[WIDTH-1], mcand};
      booth_sum = upper;
      case (prod[1:0])
         2'b01:   booth_sum = upper + mcand_x;
         2'b10:   booth_sum = upper - mcand_x;
         default: booth_sum = upper;
      endcase
      prod_next = {booth_sum[WIDTH], booth_sum, prod[WIDTH:1]};

      rem_sh  = {rem, quo[WIDTH-1]};
      rem_ge  = rem_sh >= {1'b0, dvsr};
      rem_sub = rem_sh[WIDTH-1:0] - dvsr;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         prod    <= '0;
         mcand   <= '0;
         dvsr    <= '0;
         rem     <= '0;
         quo     <= '0;
         a_sign  <= 1'b0;
         b_sign  <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
         Hi      <= '0;
         Lo      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  cnt    <= CNT_W'(WIDTH - 1);
                  mcand  <= A;
                  prod   <= {(WIDTH + 1)'(0), B, 1'b0};
                  a_sign <= A[WIDTH-1];
                  b_sign <= B[WIDTH-1];
                  quo    <= mag(A);
                  dvsr   <= mag(B);
                  rem    <= '0;
                  if (!Op) begin
                     state <= S_MULT;
                     Busy  <= 1'b1;
                  end else if (B != '0) begin
                     state <= S_DIV;
                     Busy  <= 1'b1;
                  end else begin
                     // Divide by zero: report at once, leave Hi/Lo untouched.
                     state   <= S_DONE;
                     Done    <= 1'b1;
                     DivZero <= 1'b1;
                  end
               end
            end
            S_MULT: begin
               prod <= prod_next;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  {Hi, Lo} <= prod_next[2*WIDTH:1];
                  state    <= S_DONE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
               end
            end
            S_DIV: begin
               rem <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], rem_ge};
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) state <= S_FIX;
            end
            S_FIX: begin
               // Quotient takes the XOR of signs, remainder follows the dividend.
               Lo    <= (a_sign ^ b_sign) ? WIDTH'(-quo) : quo;
               Hi    <= a_sign ? WIDTH'(-rem) : rem;
               state <= S_DONE;
               Busy  <= 1'b0;
               Done  <= 1'b1;
            end
            S_DONE: begin
               state   <= S_IDLE;
               Done    <= 1'b0;
               DivZero <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               Busy    <= 1'b0;
               Done    <= 1'b0;
               DivZero <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: latency, results, divide-by-zero,
// ignored Start pulses and asynchronous reset abort.
module tb_mult_div_seq;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic        DivZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int n_cmp = 0;
   int n_err = 0;

   mult_div_seq #(.WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch, wait for Done (bounded), then check latency and result.
   // inject > 0 pulses Start with new operands before that edge number.
   // start_in_done holds Start high through the DONE cycle.
   task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input int inject, input bit start_in_done,
                         input int exp_lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz);
      int lat;
      bit busy_seen;
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0;
      lat = 0;
      busy_seen = Busy;
      while (!Done && lat < 40) begin
         if (inject > 0 && lat + 1 == inject) begin
            @(negedge Clk);
            Start = 1'b1; Op = 1'b1; A = 32'd100; B = 32'd100;
         end
         @(posedge Clk); #1;
         Start = 1'b0;
         A = 32'h0; B = 32'h0;
         lat++;
         busy_seen = busy_seen | Busy;
         check($sformatf("%s_busy_and_done", tag), {31'b0, Busy & Done}, 32'd0);
      end
      check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_hi", tag), Hi, exp_hi);
      check($sformatf("%s_lo", tag), Lo, exp_lo);
      check($sformatf("%s_divzero", tag), {31'b0, DivZero}, {31'b0, exp_dz});
      check($sformatf("%s_busy_seen", tag), {31'b0, busy_seen}, {31'b0, exp_lat != 0});
      if (start_in_done) begin
         @(negedge Clk);
         Start = 1'b1; Op = 1'b0; A = 32'd1; B = 32'd1;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      check($sformatf("%s_done_drop", tag), {31'b0, Done}, 32'd0);
      check($sformatf("%s_dz_drop", tag), {31'b0, DivZero}, 32'd0);
      if (start_in_done) begin
         @(posedge Clk); #1;
         check($sformatf("%s_done_start_ignored", tag), {31'b0, Busy}, 32'd0);
      end
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Op = 1'b0; A = 32'h0; B = 32'h0;
      #12;
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_done", {31'b0, Done}, 32'd0);
      check("rst_divzero", {31'b0, DivZero}, 32'd0);
      check("rst_hi", Hi, 32'h0);
      check("rst_lo", Lo, 32'h0);
      @(negedge Clk);
      Reset = 1'b1;

      run_op("mul_7_m3",   1'b0, 32'd7,        32'hFFFFFFFD, 0, 1'b0, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run_op("mul_min_sq", 1'b0, 32'h80000000, 32'h80000000, 0, 1'b0, 32, 32'h40000000, 32'h00000000, 1'b0);
      run_op("mul_m1_1",   1'b0, 32'hFFFFFFFF, 32'd1,        0, 1'b0, 32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        0, 1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("div_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 0, 1'b0, 33, 32'd1,        32'hFFFFFFFD, 1'b0);
      run_op("div_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 33, 32'h0,        32'h80000000, 1'b0);
      run_op("div_prep",   1'b1, 32'h451,      32'h20,       0, 1'b0, 33, 32'h11,       32'h22,       1'b0);
      run_op("div_zero",   1'b1, 32'd5,        32'd0,        0, 1'b0, 0,  32'h11,       32'h22,       1'b1);
      run_op("mul_ignore", 1'b0, 32'd3,        32'd5,        10, 1'b1, 32, 32'h0,       32'd15,       1'b0);

      // Asynchronous reset in the middle of a divide.
      @(negedge Clk);
      Start = 1'b1; Op = 1'b1; A = 32'd1000; B = 32'd3;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge Clk); #1;
      end
      check("abort_busy_before", {31'b0, Busy}, 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      check("abort_busy", {31'b0, Busy}, 32'd0);
      check("abort_done", {31'b0, Done}, 32'd0);
      check("abort_divzero", {31'b0, DivZero}, 32'd0);
      check("abort_hi", Hi, 32'h0);
      check("abort_lo", Lo, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         check("abort_no_done", {31'b0, Done | Busy}, 32'd0);
      end
      @(negedge Clk);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         check("post_abort_idle", {31'b0, Done | Busy}, 32'd0);
      end

      run_op("div_100_7", 1'b1, 32'd100, 32'd7, 0, 1'b0, 33, 32'd2, 32'd14, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
